// File: rtl/fc_pkg.sv
// Shared types and helpers for the streaming fully-connected layer.
// Optional build macro FC_SATURATE_EN switches sat_trunc from truncation to clamping.
package fc_pkg;

  // Wide enough for any sensible BITWIDTH/IN_DIM combination.
  localparam int unsigned MaxAccW = 96;

  typedef enum logic {ACCUM, DRAIN} state_e;

  function automatic int unsigned acc_width(int unsigned bitwidth, int unsigned in_dim);
    return 2 * bitwidth + $clog2(in_dim);
  endfunction

  // Rescale a sign-extended accumulator; caller keeps the low bitwidth bits.
  function automatic logic signed [MaxAccW-1:0] sat_trunc(logic signed [MaxAccW-1:0] acc,
                                                          int unsigned bitwidth,
                                                          int unsigned frac_shift);
`ifdef FC_SATURATE_EN
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    logic signed [MaxAccW-1:0] shifted;
    shifted = acc >>> frac_shift;
    hi = (MaxAccW'(1) <<< (bitwidth - 1)) - MaxAccW'(1);
    lo = ~hi;
    if (shifted > hi) begin
      shifted = hi;
    end else if (shifted < lo) begin
      shifted = lo;
    end
    return shifted;
`else
    return acc >>> frac_shift;
`endif
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One multiply-accumulate lane; 'first' overwrites the accumulator instead of adding to it.
module fc_mac_lane #(
  parameter int unsigned BitWidth = 16,
  parameter int unsigned AccW     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       first_i,
  input  logic signed [BitWidth-1:0] x_i,
  input  logic signed [BitWidth-1:0] w_i,
  output logic signed [AccW-1:0]     acc_o
);

  logic signed [2*BitWidth-1:0] prod;
  logic signed [AccW-1:0]       acc_q;
  logic signed [AccW-1:0]       acc_d;

  assign prod = x_i * w_i;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = (first_i ? '0 : acc_q) + {{(AccW - 2 * BitWidth){prod[2*BitWidth-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_stream.sv
// Sequential FC layer: inputs stream in, OUT_DIM lanes accumulate, results drain serially.
// Build macro FC_SATURATE_EN clamps each result instead of truncating it.
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int unsigned BITWIDTH   = 16,
  parameter int unsigned IN_DIM     = 10,
  parameter int unsigned OUT_DIM    = 10,
  parameter int unsigned FRAC_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_we,
  input  logic [$clog2(OUT_DIM)-1:0] w_row,
  input  logic [$clog2(IN_DIM)-1:0]  w_col,
  input  logic signed [BITWIDTH-1:0] w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_data,
  output logic [$clog2(OUT_DIM)-1:0] out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned AccW = acc_width(BITWIDTH, IN_DIM);
  localparam int unsigned RowW = $clog2(OUT_DIM);
  localparam int unsigned ColW = $clog2(IN_DIM);
  localparam logic [RowW-1:0] RowLast = RowW'(OUT_DIM - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(IN_DIM - 1);

  state_e                     state_q;
  logic [ColW-1:0]            in_cnt_q;
  logic [RowW-1:0]            out_idx_q;
  logic signed [BITWIDTH-1:0] w_q [OUT_DIM][IN_DIM];
  logic signed [AccW-1:0]     acc [OUT_DIM];
  logic                       in_hs;
  logic                       out_hs;
  logic                       w_ok;
  logic signed [MaxAccW-1:0]  acc_ext;
  logic signed [MaxAccW-1:0]  res;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (out_idx_q == RowLast);
  assign busy      = (in_cnt_q != '0) || (state_q == DRAIN);
  assign out_idx   = out_idx_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // Range check matters only when a dimension is not a power of two.
  assign w_ok      = w_we && !busy && (w_row <= RowLast) && (w_col <= ColLast);

  always_comb begin
    acc_ext  = MaxAccW'(acc[out_idx_q]);
    res      = sat_trunc(acc_ext, BITWIDTH, FRAC_SHIFT);
    out_data = BITWIDTH'(res);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      in_cnt_q  <= '0;
      out_idx_q <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_hs) begin
            if (in_cnt_q == ColLast) begin
              in_cnt_q <= '0;
              state_q  <= DRAIN;
            end else begin
              in_cnt_q <= in_cnt_q + ColW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (out_last) begin
              out_idx_q <= '0;
              state_q   <= ACCUM;
            end else begin
              out_idx_q <= out_idx_q + RowW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(OUT_DIM); j++) begin
        for (int i = 0; i < int'(IN_DIM); i++) begin
          w_q[j][i] <= '0;
        end
      end
    end else if (w_ok) begin
      w_q[w_row][w_col] <= w_data;
    end
  end

  for (genvar j = 0; j < int'(OUT_DIM); j++) begin : g_lane
    fc_mac_lane #(
      .BitWidth(BITWIDTH),
      .AccW    (AccW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_i   (in_hs),
      .first_i(in_cnt_q == '0),
      .x_i    (in_data),
      .w_i    (w_q[j][in_cnt_q]),
      .acc_o  (acc[j])
    );
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Scoreboard bench for fc_layer_stream: stimulus pushes expected results, a monitor pops them.
module tb_fc_layer_stream;

  localparam int ID = 10;
  localparam int OD = 10;

`ifdef FC_SATURATE_EN
  localparam int OvfExp = 32767;
`else
  localparam int OvfExp = -2560;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               w_we;
  logic [3:0]         w_row;
  logic [3:0]         w_col;
  logic signed [15:0] w_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         out_idx;
  logic               out_last;
  logic               busy;

  fc_layer_stream #(
    .BITWIDTH  (16),
    .IN_DIM    (ID),
    .OUT_DIM   (OD),
    .FRAC_SHIFT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_we     (w_we),
    .w_row    (w_row),
    .w_col    (w_col),
    .w_data   (w_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] data;
    logic [3:0]         idx;
    logic               last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   rnd_ready = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic push(input int d, input int j);
    exp_t e;
    e.data = 16'(d);
    e.idx  = 4'(j);
    e.last = (j == OD - 1);
    exp_q.push_back(e);
  endtask

  // Downstream ready: always high, or random when rnd_ready is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: compare each accepted result and check holds while stalled.
  initial begin
    bit                 stall_p;
    logic signed [15:0] held_d;
    logic [3:0]         held_i;
    exp_t               e;
    stall_p = 1'b0;
    held_d  = '0;
    held_i  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p && out_valid) begin
          check(out_data == held_d, "hold_data", out_data, held_d);
          check(out_idx == held_i, "hold_idx", out_idx, held_i);
        end
        stall_p = 1'b0;
        if (out_valid) begin
          check(in_ready == 1'b0, "in_ready_in_drain", in_ready, 0);
          if (!out_ready) begin
            stall_p = 1'b1;
            held_d  = out_data;
            held_i  = out_idx;
          end else if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_output", out_idx, -1);
          end else begin
            e = exp_q.pop_front();
            check(out_data == e.data, "out_data", out_data, e.data);
            check(out_idx == e.idx, "out_idx", out_idx, e.idx);
            check(out_last == e.last, "out_last", out_last, e.last);
          end
        end
      end
    end
  end

  task automatic wr(input int r, input int c, input int d);
    w_we   = 1'b1;
    w_row  = 4'(r);
    w_col  = 4'(c);
    w_data = 16'(d);
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  task automatic load_ident();
    for (int j = 0; j < OD; j++)
      for (int i = 0; i < ID; i++) wr(j, i, (i == j) ? 256 : 0);
  endtask

  task automatic push_ident();
    for (int j = 0; j < OD; j++) push(j * 256, j);
  endtask

  // Stream one frame; optional input bubbles and an attempted write at element wr_at.
  task automatic send_frame(input int x[ID], input bit bub, input int wr_at);
    for (int i = 0; i < ID; i++) begin
      if (bub) begin
        for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      if (i == wr_at) begin
        in_valid = 1'b0;
        check(busy == 1'b1, "busy_mid_frame", busy, 1);
        wr(0, 5, 999);
      end
      if (i == 0) check(in_ready == 1'b1, "in_ready_accum", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 16'(x[i]);
      if (i == ID - 1) check(out_valid == 1'b0, "valid_before_last", out_valid, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check(out_valid == 1'b1, "first_result_latency", out_valid, 1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    int xi[ID];
    int xz[ID];
    int xm[ID];
    bit found;
    for (int i = 0; i < ID; i++) begin
      xi[i] = i * 256;
      xz[i] = 0;
      xm[i] = 32767;
    end
    xz[0]    = -1;
    rst      = 1'b1;
    w_we     = 1'b0;
    w_row    = '0;
    w_col    = '0;
    w_data   = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check(in_ready == 1'b1, "reset_in_ready", in_ready, 1);
    check(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    check(out_last == 1'b0, "reset_out_last", out_last, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(out_data == 16'sd0, "reset_out_data", out_data, 0);
    rst = 1'b0;

    // Identity weights.
    load_ident();
    push_ident();
    send_frame(xi, 1'b0, -1);
    wait_drain();

    // Arithmetic shift floors -1/256 to -1.
    for (int j = 0; j < OD; j++)
      for (int i = 0; i < ID; i++) wr(j, i, (i == 0 && j == 0) ? 1 : 0);
    push(-1, 0);
    for (int j = 1; j < OD; j++) push(0, j);
    send_frame(xz, 1'b0, -1);
    wait_drain();

    // Full-scale products: shifted sum 41940480.
    for (int j = 0; j < OD; j++)
      for (int i = 0; i < ID; i++) wr(j, i, 32767);
    for (int j = 0; j < OD; j++) push(OvfExp, j);
    send_frame(xm, 1'b0, -1);
    wait_drain();

    // Bubbles and backpressure.
    load_ident();
    rnd_ready = 1'b1;
    repeat (2) begin
      push_ident();
      send_frame(xi, 1'b1, -1);
      wait_drain();
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Write while busy is dropped; same write lands when idle.
    push_ident();
    send_frame(xi, 1'b0, 3);
    wait_drain();
    wr(0, 5, 999);
    push(4995, 0);
    for (int j = 1; j < OD; j++) push(j * 256, j);
    send_frame(xi, 1'b0, -1);
    wait_drain();

    // Reset in the middle of the drain.
    load_ident();
    push_ident();
    send_frame(xi, 1'b0, -1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (out_valid && out_idx == 4'd4) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check(found, "reach_idx4", found, 1);
    rst = 1'b1;
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
    check(in_ready == 1'b1, "midrst_in_ready", in_ready, 1);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(out_data == 16'sd0, "midrst_out_data", out_data, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Weights were cleared by reset.
    for (int j = 0; j < OD; j++) push(0, j);
    send_frame(xi, 1'b0, -1);
    wait_drain();
    load_ident();
    push_ident();
    send_frame(xi, 1'b0, -1);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
